// File: rtl/dyt_rf_wb_arbiter.sv
// Round-robin writeback arbiter feeding the register file write port.
// Optional read bypass ports: define DYT_WB_BYPASS_EN.
module dyt_rf_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef DYT_WB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0]         byp_a_addr,
  input  logic [DATA_WIDTH-1:0]         byp_a_rf_data,
  output logic [DATA_WIDTH-1:0]         byp_a_data,
  input  logic [ADDR_WIDTH-1:0]         byp_b_addr,
  input  logic [DATA_WIDTH-1:0]         byp_b_rf_data,
  output logic [DATA_WIDTH-1:0]         byp_b_data,
`endif
  output logic                          w_en,
  output logic [ADDR_WIDTH-1:0]         w_addr,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [2:0]                    grant_id
);

  localparam logic [2:0] LAST = 3'(NUM_REQ - 1);

  logic [2:0]            rr_ptr;
  logic [2:0]            gnt_idx;
  logic                  gnt_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  int                    idx;

  // Scan downward so the requester nearest rr_ptr is assigned last and wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(idx);
      end
    end
    if (wb_stall || !rst) gnt_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_any && (gnt_idx == 3'(i));
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      w_en     <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      grant_id <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == LAST) ? 3'd0 : gnt_idx + 3'd1;
      // x0 transfers complete but never reach the register file.
      if (sel_addr != '0) begin
        w_en     <= 1'b1;
        w_addr   <= sel_addr;
        w_data   <= sel_data;
        grant_id <= gnt_idx;
      end else begin
        w_en <= 1'b0;
      end
    end else begin
      w_en <= 1'b0;
    end
  end

`ifdef DYT_WB_BYPASS_EN
  always_comb begin
    byp_a_data = byp_a_rf_data;
    byp_b_data = byp_b_rf_data;
    if (w_en && w_addr == byp_a_addr && byp_a_addr != '0)
      byp_a_data = w_data;
    if (w_en && w_addr == byp_b_addr && byp_b_addr != '0)
      byp_b_data = w_data;
  end
`endif

endmodule
